ryu_jump_controller: RTL and testbench

Frame-rate motion sequencer for the Ryu jump sprite. It turns a jump keypress into a vertical trajectory: a rise under constant deceleration, a fall under constant acceleration, and a short landing hold. Each frame it drives the sprite's Y position and the idle/jump sprite select. It sits between the keyboard decode and the sprite renderers. Its `RyuY` output feeds the `RyuY` input of the jump sprite, and `sprite_sel` chooses which sprite's `ryu_on` and colour reach the frame mux.

---
 rtl/ryu_jump_controller.sv | 152 +++++++++++++++
 tb/tb_ryu_jump_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ryu_jump_controller.sv
// Frame-rate jump sequencer for the Ryu sprite: turns a jump keypress into a
// rise/fall trajectory and a landing hold, updating only on vertical-sync ticks.
module ryu_jump_controller #(
  parameter logic [9:0] GROUND_Y    = 10'd300,
  parameter logic [5:0] JUMP_V      = 6'd12,
  parameter logic [3:0] LAND_FRAMES = 4'd4
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic       jump_key,
  output logic [9:0] RyuY,
  output logic       sprite_sel,
  output logic       jump_active,
  output logic       land_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd2,
    S_LAND = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_vs_q;
  logic       r_key_q;
  logic       r_jump_req;
  logic       r_land_pulse;
  logic [9:0] r_y;
  logic [5:0] r_vy;
  logic [3:0] r_land_cnt;

  logic       w_tick;
  logic       w_key_rise;
  logic       w_req_nxt;
  logic       w_land_entry;
  logic [9:0] w_y_nxt;
  logic [5:0] w_vy_nxt;
  logic [3:0] w_land_cnt_nxt;
  logic [5:0] w_v1;
  logic [9:0] w_y1;

  // One tick per falling edge of vs; vs_q resets low so a release during vs=0 is silent.
  assign w_tick     = r_vs_q & ~vs;
  assign w_key_rise = jump_key & ~r_key_q;

  // Candidate fall step: speed grows by one pixel/frame before it is applied.
  assign w_v1 = r_vy + 6'd1;
  assign w_y1 = r_y + {4'd0, w_v1};

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_y_nxt        = r_y;
    w_vy_nxt       = r_vy;
    w_land_cnt_nxt = r_land_cnt;
    w_req_nxt      = r_jump_req;
    w_land_entry   = 1'b0;

    // Requests are only latched while idle; presses mid-jump are dropped, not queued.
    if ((r_state == S_IDLE) && w_key_rise) begin
      w_req_nxt = 1'b1;
    end

    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          w_y_nxt = GROUND_Y;
          if (r_jump_req) begin
            w_vy_nxt    = JUMP_V;
            w_req_nxt   = 1'b0;
            w_state_nxt = S_RISE;
          end
        end
        S_RISE: begin
          w_y_nxt = r_y - {4'd0, r_vy};
          if (r_vy <= 6'd1) begin
            w_vy_nxt    = 6'd0;
            w_state_nxt = S_FALL;
          end else begin
            w_vy_nxt = r_vy - 6'd1;
          end
        end
        S_FALL: begin
          if (w_y1 >= GROUND_Y) begin
            w_y_nxt        = GROUND_Y;
            w_vy_nxt       = 6'd0;
            w_land_cnt_nxt = LAND_FRAMES;
            w_land_entry   = 1'b1;
            w_state_nxt    = S_LAND;
          end else begin
            w_y_nxt  = w_y1;
            w_vy_nxt = w_v1;
          end
        end
        S_LAND: begin
          w_y_nxt = GROUND_Y;
          if (r_land_cnt <= 4'd1) begin
            w_land_cnt_nxt = 4'd0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_land_cnt_nxt = r_land_cnt - 4'd1;
          end
        end
        default: begin
          w_y_nxt     = GROUND_Y;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_vs_q       <= 1'b0;
      r_key_q      <= 1'b0;
      r_jump_req   <= 1'b0;
      r_land_pulse <= 1'b0;
      r_y          <= GROUND_Y;
      r_vy         <= 6'd0;
      r_land_cnt   <= 4'd0;
    end else begin
      r_vs_q       <= vs;
      r_key_q      <= jump_key;
      r_jump_req   <= w_req_nxt;
      r_land_pulse <= w_land_entry;
      r_y          <= w_y_nxt;
      r_vy         <= w_vy_nxt;
      r_land_cnt   <= w_land_cnt_nxt;
    end
  end

  assign RyuY        = r_y;
  assign sprite_sel  = (r_state != S_IDLE);
  assign jump_active = (r_state == S_RISE) || (r_state == S_FALL);
  assign land_pulse  = r_land_pulse;

endmodule

// File: tb/tb_ryu_jump_controller.sv
// Directed bench for ryu_jump_controller: frames are built from a vs waveform,
// and each scenario task checks the trajectory against hand-derived values.
module tb_ryu_jump_controller;

  localparam int GY   = 300;
  localparam int JV   = 12;
  localparam int LF   = 4;
  localparam int APEX = GY - JV * (JV + 1) / 2;

  logic       vga_clk;
  logic       Reset;
  logic       vs;
  logic       jump_key;
  logic [9:0] RyuY;
  logic       sprite_sel;
  logic       jump_active;
  logic       land_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int land_cnt = 0;

  ryu_jump_controller dut (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .vs         (vs),
    .jump_key   (jump_key),
    .RyuY       (RyuY),
    .sprite_sel (sprite_sel),
    .jump_active(jump_active),
    .land_pulse (land_pulse)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Counts every cycle land_pulse is seen high, so a stretched pulse shows up as >1.
  always @(negedge vga_clk) begin
    if (!Reset && land_pulse === 1'b1) land_cnt++;
  end

  // Height after k rise ticks: sum of JV, JV-1, ..., JV-k+1 pixels removed.
  function automatic int rise_y(input int k);
    return GY - (JV * k - k * (k - 1) / 2);
  endfunction

  // Height after k fall ticks from the apex, clamped to the ground.
  function automatic int fall_y(input int k);
    int y;
    y = APEX + k * (k + 1) / 2;
    return (y > GY) ? GY : y;
  endfunction

  // One video frame: vs high 4 cycles then low 4; the single tick lands on the
  // first low cycle, so outputs are settled when this returns.
  task automatic frame();
    repeat (4) begin @(negedge vga_clk); vs = 1'b1; end
    repeat (4) begin @(negedge vga_clk); vs = 1'b0; end
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press_key();
    @(negedge vga_clk); jump_key = 1'b1;
    @(negedge vga_clk); jump_key = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; vs = 1'b0; jump_key = 1'b0;
    repeat (2) @(negedge vga_clk);
    n_checks++;
    if (RyuY !== 10'(GY) || sprite_sel !== 1'b0 || jump_active !== 1'b0 || land_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: RyuY=%0d sel=%b act=%b pulse=%b, expected 300/0/0/0",
               RyuY, sprite_sel, jump_active, land_pulse);
    end
    Reset = 1'b0;
    @(negedge vga_clk);
    n_checks++;
    if (RyuY !== 10'(GY) || sprite_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: RyuY=%0d sel=%b, expected 300/0", RyuY, sprite_sel);
    end
    for (int f = 0; f < 3; f++) begin
      frame();
      n_checks++;
      if (RyuY !== 10'(GY) || sprite_sel !== 1'b0 || jump_active !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_frame[%0d]: RyuY=%0d sel=%b act=%b, expected 300/0/0",
                 f, RyuY, sprite_sel, jump_active);
      end
    end
    n_checks++;
    if (land_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_no_land: land pulses=%0d, expected 0", land_cnt);
    end
  endtask

  task automatic test_single_jump();
    int lc0;
    lc0 = land_cnt;
    press_key();
    frame();
    n_checks++;
    if (RyuY !== 10'(GY) || sprite_sel !== 1'b1 || jump_active !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_start: RyuY=%0d sel=%b act=%b, expected 300/1/1",
               RyuY, sprite_sel, jump_active);
    end
    for (int k = 1; k <= JV; k++) begin
      frame();
      n_checks++;
      if (RyuY !== 10'(rise_y(k)) || jump_active !== 1'b1) begin
        n_fail++;
        $display("FAIL rise[%0d]: RyuY=%0d act=%b, expected %0d/1", k, RyuY, jump_active, rise_y(k));
      end
    end
    for (int k = 1; k <= JV; k++) begin
      frame();
      n_checks++;
      if (RyuY !== 10'(fall_y(k)) || jump_active !== (k < JV)) begin
        n_fail++;
        $display("FAIL fall[%0d]: RyuY=%0d act=%b, expected %0d/%0b",
                 k, RyuY, jump_active, fall_y(k), (k < JV));
      end
    end
    n_checks++;
    if (land_cnt - lc0 !== 1 || land_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL land_pulse_once: pulses=%0d now=%b, expected 1/0", land_cnt - lc0, land_pulse);
    end
    for (int k = 1; k <= LF; k++) begin
      frame();
      n_checks++;
      if (sprite_sel !== (k < LF) || RyuY !== 10'(GY)) begin
        n_fail++;
        $display("FAIL land_hold[%0d]: sel=%b RyuY=%0d, expected %0b/300", k, sprite_sel, RyuY, (k < LF));
      end
    end
  endtask

  task automatic test_held_key();
    int lc0;
    int active_frames;
    lc0 = land_cnt;
    active_frames = 0;
    @(negedge vga_clk); jump_key = 1'b1;
    for (int f = 0; f < 60; f++) begin
      frame();
      if (jump_active === 1'b1) active_frames++;
    end
    n_checks++;
    if (active_frames !== 2 * JV || land_cnt - lc0 !== 1) begin
      n_fail++;
      $display("FAIL held_one_jump: airborne frames=%0d landings=%0d, expected %0d/1",
               active_frames, land_cnt - lc0, 2 * JV);
    end
    n_checks++;
    if (sprite_sel !== 1'b0 || RyuY !== 10'(GY)) begin
      n_fail++;
      $display("FAIL held_idle: sel=%b RyuY=%0d, expected 0/300", sprite_sel, RyuY);
    end
    @(negedge vga_clk); jump_key = 1'b0;
    press_key();
    frame();
    n_checks++;
    if (jump_active !== 1'b1) begin
      n_fail++;
      $display("FAIL held_repress: act=%b, expected 1", jump_active);
    end
    run_frames(2 * JV + LF);
    n_checks++;
    if (sprite_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL held_repress_done: sel=%b, expected 0", sprite_sel);
    end
  endtask

  task automatic test_press_during_jump();
    int lc0;
    lc0 = land_cnt;
    press_key();
    frame();
    run_frames(4);
    press_key();
    frame();
    n_checks++;
    if (RyuY !== 10'(rise_y(5))) begin
      n_fail++;
      $display("FAIL midrise_press_y: RyuY=%0d, expected %0d", RyuY, rise_y(5));
    end
    run_frames(JV - 5);
    run_frames(JV);
    press_key();
    run_frames(LF);
    run_frames(2);
    n_checks++;
    if (jump_active !== 1'b0 || sprite_sel !== 1'b0 || RyuY !== 10'(GY) || land_cnt - lc0 !== 1) begin
      n_fail++;
      $display("FAIL ignored_presses: act=%b sel=%b RyuY=%0d landings=%0d, expected 0/0/300/1",
               jump_active, sprite_sel, RyuY, land_cnt - lc0);
    end
  endtask

  task automatic test_reset_midair();
    press_key();
    frame();
    run_frames(JV);
    run_frames(3);
    n_checks++;
    if (RyuY !== 10'(fall_y(3))) begin
      n_fail++;
      $display("FAIL fall3_y: RyuY=%0d, expected %0d", RyuY, fall_y(3));
    end
    @(negedge vga_clk); Reset = 1'b1;
    @(negedge vga_clk);
    n_checks++;
    if (RyuY !== 10'(GY) || sprite_sel !== 1'b0 || jump_active !== 1'b0) begin
      n_fail++;
      $display("FAIL midair_reset: RyuY=%0d sel=%b act=%b, expected 300/0/0", RyuY, sprite_sel, jump_active);
    end
    Reset = 1'b0;
    run_frames(2);
    press_key();
    frame();
    n_checks++;
    if (jump_active !== 1'b1 || RyuY !== 10'(GY)) begin
      n_fail++;
      $display("FAIL post_reset_start: act=%b RyuY=%0d, expected 1/300", jump_active, RyuY);
    end
    frame();
    n_checks++;
    if (RyuY !== 10'(rise_y(1))) begin
      n_fail++;
      $display("FAIL post_reset_rise1: RyuY=%0d, expected %0d", RyuY, rise_y(1));
    end
    run_frames(JV - 1 + JV + LF);
    // A request pending at reset must be discarded.
    press_key();
    @(negedge vga_clk); Reset = 1'b1;
    @(negedge vga_clk); Reset = 1'b0;
    run_frames(2);
    n_checks++;
    if (sprite_sel !== 1'b0 || jump_active !== 1'b0 || RyuY !== 10'(GY)) begin
      n_fail++;
      $display("FAIL pending_req_dropped: sel=%b act=%b RyuY=%0d, expected 0/0/300",
               sprite_sel, jump_active, RyuY);
    end
  endtask

  task automatic test_edge_coincidence();
    repeat (4) begin @(negedge vga_clk); vs = 1'b1; end
    @(negedge vga_clk); vs = 1'b0; jump_key = 1'b1;
    @(negedge vga_clk); jump_key = 1'b0;
    repeat (2) @(negedge vga_clk);
    n_checks++;
    if (jump_active !== 1'b0 || RyuY !== 10'(GY)) begin
      n_fail++;
      $display("FAIL coincide_tick0: act=%b RyuY=%0d, expected 0/300", jump_active, RyuY);
    end
    frame();
    n_checks++;
    if (jump_active !== 1'b1 || RyuY !== 10'(GY)) begin
      n_fail++;
      $display("FAIL coincide_start: act=%b RyuY=%0d, expected 1/300", jump_active, RyuY);
    end
    frame();
    n_checks++;
    if (RyuY !== 10'(rise_y(1))) begin
      n_fail++;
      $display("FAIL coincide_rise1: RyuY=%0d, expected %0d", RyuY, rise_y(1));
    end
    run_frames(JV - 1 + JV + LF);
    n_checks++;
    if (sprite_sel !== 1'b0 || RyuY !== 10'(GY)) begin
      n_fail++;
      $display("FAIL coincide_done: sel=%b RyuY=%0d, expected 0/300", sprite_sel, RyuY);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    vs       = 1'b0;
    jump_key = 1'b0;
    test_reset();
    test_single_jump();
    test_held_key();
    test_press_during_jump();
    test_reset_midair();
    test_edge_coincidence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
